// File: rtl/bpu_update_scheduler_if.sv
// Update/table bus between the Memory-stage pipeline (master) and the BPU update scheduler (slave).
interface bpu_update_scheduler_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TGT_W  = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              branch1;
    logic              branch_taken1;
    logic [ADDR_W-1:0] pcM1;
    logic [TGT_W-1:0]  targetM1;
    logic              branch2;
    logic              branch_taken2;
    logic [ADDR_W-1:0] pcM2;
    logic [TGT_W-1:0]  targetM2;

    logic              upd_full;
    logic              init_busy;
    logic              overflow;
    logic [CNT_W-1:0]  upd_count;
    logic              tbl_we;
    logic              tbl_clr;
    logic [ADDR_W-1:0] tbl_addr;
    logic              tbl_taken;
    logic [TGT_W-1:0]  tbl_target;

    modport master (
        output branch1, branch_taken1, pcM1, targetM1,
        output branch2, branch_taken2, pcM2, targetM2,
        input  upd_full, init_busy, overflow, upd_count,
        input  tbl_we, tbl_clr, tbl_addr, tbl_taken, tbl_target
    );

    modport slave (
        input  branch1, branch_taken1, pcM1, targetM1,
        input  branch2, branch_taken2, pcM2, targetM2,
        output upd_full, init_busy, overflow, upd_count,
        output tbl_we, tbl_clr, tbl_addr, tbl_taken, tbl_target
    );
endinterface

// File: rtl/bpu_update_scheduler.sv
// Serialises up to two branch updates per cycle into one BHT/BTB write port via a small FIFO.
// Define BPU_INIT_SWEEP_EN to add the post-reset INIT sweep that clears every table entry.
module bpu_update_scheduler #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TGT_W  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic               clk,
    input logic               reset,
    bpu_update_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = ADDR_W + 1 + TGT_W;

    typedef enum logic {StInit, StRun} state_e;

`ifdef BPU_INIT_SWEEP_EN
    localparam state_e ResetState = StInit;
    logic [ADDR_W-1:0] r_sweep;
    logic              r_init_busy;
`else
    localparam state_e ResetState = StRun;
`endif

    state_e           r_state;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [ENT_W-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_pop;
    logic [CNT_W:0]   w_room;
    logic             w_acc1;
    logic             w_acc2;
    logic             w_drop;
    logic [PTR_W-1:0] w_wptr2;
    logic [ENT_W-1:0] w_head;
    logic             w_near_full;

    always_comb begin
        w_run  = (r_state == StRun);
        w_pop  = w_run && (r_count != '0);
        // Room counts the slot vacated by this cycle's pop.
        w_room = (CNT_W+1)'(DEPTH) - {1'b0, r_count} + (CNT_W+1)'(w_pop);
        w_acc1 = w_run && bus.branch1 && (w_room >= (CNT_W+1)'(1));
        w_acc2 = w_run && bus.branch2 &&
                 (w_room >= ((CNT_W+1)'(1) + (CNT_W+1)'(w_acc1)));
        w_drop = w_run && ((bus.branch1 && !w_acc1) || (bus.branch2 && !w_acc2));
        w_wptr2     = r_wptr + PTR_W'(w_acc1);
        w_head      = r_mem[r_rptr];
        w_near_full = (r_count >= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ResetState;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
`ifdef BPU_INIT_SWEEP_EN
            r_sweep     <= '0;
            r_init_busy <= 1'b1;
`endif
        end else begin
            unique case (r_state)
`ifdef BPU_INIT_SWEEP_EN
                StInit: begin
                    r_sweep <= r_sweep + ADDR_W'(1);
                    if (&r_sweep) begin
                        r_state     <= StRun;
                        r_init_busy <= 1'b0;
                    end
                end
`endif
                StRun: begin
                    r_rptr  <= r_rptr + PTR_W'(w_pop);
                    r_wptr  <= r_wptr + PTR_W'(w_acc1) + PTR_W'(w_acc2);
                    r_count <= r_count + CNT_W'(w_acc1) + CNT_W'(w_acc2) - CNT_W'(w_pop);
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (w_acc1) begin
            r_mem[r_wptr] <= {bus.pcM1, bus.branch_taken1, bus.targetM1};
        end
        if (w_acc2) begin
            r_mem[w_wptr2] <= {bus.pcM2, bus.branch_taken2, bus.targetM2};
        end
    end

    always_comb begin
        bus.tbl_we     = w_pop;
        bus.tbl_taken  = w_pop ? w_head[TGT_W] : 1'b0;
        bus.tbl_target = w_pop ? w_head[TGT_W-1:0] : '0;
        bus.overflow   = r_overflow;
        bus.upd_count  = r_count;
`ifdef BPU_INIT_SWEEP_EN
        bus.tbl_clr    = !w_run;
        bus.init_busy  = r_init_busy;
        bus.upd_full   = !w_run || w_near_full;
        bus.tbl_addr   = !w_run ? r_sweep : (w_pop ? w_head[ENT_W-1 -: ADDR_W] : '0);
`else
        bus.tbl_clr    = 1'b0;
        bus.init_busy  = 1'b0;
        bus.upd_full   = w_near_full;
        bus.tbl_addr   = w_pop ? w_head[ENT_W-1 -: ADDR_W] : '0;
`endif
    end
endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Self-checking bench for bpu_update_scheduler: directed steps plus random traffic against a queue model.
module tb_bpu_update_scheduler;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TGT_W  = 8;
    localparam int unsigned DEPTH  = 4;
`ifdef BPU_INIT_SWEEP_EN
    localparam int INIT_LEN = 1 << ADDR_W;
`else
    localparam int INIT_LEN = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bpu_update_scheduler_if #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .DEPTH(DEPTH)) bus ();

    bpu_update_scheduler #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of {pc, taken, target}, sticky overflow, remaining init cycles.
    logic [16:0] q[$];
    bit          m_ovf;
    int          m_init_left;
    int          m_sweep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf       = 1'b0;
        m_init_left = INIT_LEN;
        m_sweep     = 0;
    endtask

    task automatic check_reset_vals();
        chk("rst_we", 32'(bus.tbl_we), 0);
        chk("rst_count", 32'(bus.upd_count), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_taken", 32'(bus.tbl_taken), 0);
        chk("rst_target", 32'(bus.tbl_target), 0);
        chk("rst_addr", 32'(bus.tbl_addr), 0);
        chk("rst_clr", 32'(bus.tbl_clr), 32'(INIT_LEN > 0));
        chk("rst_busy", 32'(bus.init_busy), 32'(INIT_LEN > 0));
        chk("rst_full", 32'(bus.upd_full), 32'(INIT_LEN > 0));
    endtask

    task automatic step(input bit b1, input bit t1, input logic [7:0] p1, input logic [7:0] g1,
                        input bit b2, input bit t2, input logic [7:0] p2, input logic [7:0] g2);
        logic [16:0] e;
        bus.branch1 = b1; bus.branch_taken1 = t1; bus.pcM1 = p1; bus.targetM1 = g1;
        bus.branch2 = b2; bus.branch_taken2 = t2; bus.pcM2 = p2; bus.targetM2 = g2;
        @(negedge clk);
        if (m_init_left > 0) begin
            chk("init_clr", 32'(bus.tbl_clr), 1);
            chk("init_addr", 32'(bus.tbl_addr), 32'(m_sweep));
            chk("init_busy", 32'(bus.init_busy), 1);
            chk("init_we", 32'(bus.tbl_we), 0);
            chk("init_full", 32'(bus.upd_full), 1);
            chk("init_count", 32'(bus.upd_count), 0);
            chk("init_ovf", 32'(bus.overflow), 0);
            m_init_left--;
            m_sweep++;
        end else begin
            chk("run_clr", 32'(bus.tbl_clr), 0);
            chk("run_busy", 32'(bus.init_busy), 0);
            chk("run_we", 32'(bus.tbl_we), 32'(q.size() > 0));
            chk("run_full", 32'(bus.upd_full), 32'(q.size() >= int'(DEPTH) - 1));
            chk("run_count", 32'(bus.upd_count), 32'(q.size()));
            chk("run_ovf", 32'(bus.overflow), 32'(m_ovf));
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", 32'(bus.tbl_addr), 32'(e[16:9]));
                chk("wr_taken", 32'(bus.tbl_taken), 32'(e[8]));
                chk("wr_target", 32'(bus.tbl_target), 32'(e[7:0]));
            end
            if (b1) begin
                if (q.size() < int'(DEPTH)) q.push_back({p1, t1, g1});
                else m_ovf = 1'b1;
            end
            if (b2) begin
                if (q.size() < int'(DEPTH)) q.push_back({p2, t2, g2});
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic rand_step(input bit respect_full);
        bit b1, b2;
        b1 = 1'($urandom_range(0, 1));
        b2 = 1'($urandom_range(0, 1));
        if (respect_full && bus.upd_full) begin
            b1 = 1'b0;
            b2 = 1'b0;
        end
        step(b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             b2, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        bus.branch1 = 0; bus.branch_taken1 = 0; bus.pcM1 = '0; bus.targetM1 = '0;
        bus.branch2 = 0; bus.branch_taken2 = 0; bus.pcM2 = '0; bus.targetM2 = '0;
        model_reset();
        #12;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Branches during the sweep must be ignored.
        for (int i = 0; i < INIT_LEN; i++) rand_step(1'b0);

        step(1, 1, 8'h10, 8'h40, 0, 0, 8'h00, 8'h00);
        idle(2);
        step(1, 1, 8'h20, 8'h55, 1, 0, 8'h21, 8'h66);
        idle(3);
        step(1, 1, 8'h30, 8'h11, 1, 1, 8'h30, 8'h22);
        idle(3);

        // Flood ignoring upd_full to provoke drops.
        for (int i = 0; i < 8; i++) begin
            step(1, 1'($urandom_range(0, 1)), 8'(8'h80 + 2 * i), 8'(i),
                 1, 1'($urandom_range(0, 1)), 8'(8'h81 + 2 * i), 8'(8'hF0 + i));
        end
        idle(6);

        for (int i = 0; i < 300; i++) rand_step(1'b1);
        idle(6);

        // Queue three entries, then reset mid-operation.
        step(1, 1, 8'hA0, 8'h01, 1, 0, 8'hA1, 8'h02);
        step(1, 1, 8'hA2, 8'h03, 1, 1, 8'hA3, 8'h04);
        chk("pre_reset_count", 32'(bus.upd_count), 3);
        reset = 1'b1;
        #1;
        check_reset_vals();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < INIT_LEN; i++) rand_step(1'b0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
